// File: rtl/mp_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_CORES cores,
// with locked bursts of up to BURST_MAX beats and per-core read-data return.
module mp_mem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int AW        = 11,
    parameter int DW        = 8,
    parameter int BURST_MAX = 4,
    localparam int IW       = $clog2(NUM_CORES),
    localparam int BW       = $clog2(BURST_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CORES-1:0]    req_i,
    input  logic [NUM_CORES-1:0]    lock_i,
    input  logic [NUM_CORES-1:0]    we_i,
    input  logic [NUM_CORES*AW-1:0] addr_i,
    input  logic [NUM_CORES*DW-1:0] wdata_i,
    output logic [NUM_CORES-1:0]    gnt_o,
    output logic [NUM_CORES-1:0]    rvalid_o,
    output logic [DW-1:0]           rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [AW-1:0]           mem_addr_o,
    output logic [DW-1:0]           mem_wdata_o,
    input  logic [DW-1:0]           mem_rdata_i,
    output logic [IW-1:0]           owner_id_o,
    output logic                    busy_o
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [BW-1:0]  beat_cnt_q, beat_cnt_d;
    logic           rd_pend_q;
    logic [IW-1:0]  rd_core_q;
    logic [DW-1:0]  rdata_q;

    logic [AW-1:0]  addr_arr [NUM_CORES];
    logic [DW-1:0]  wdata_arr [NUM_CORES];
    logic [IW-1:0]  winner;
    logic [IW-1:0]  owner_inc;
    logic           beat_grant;

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
        assign addr_arr[gi]  = addr_i[gi*AW +: AW];
        assign wdata_arr[gi] = wdata_i[gi*DW +: DW];
        assign gnt_o[gi]     = beat_grant && (owner_q == IW'(gi));
        assign rvalid_o[gi]  = rd_pend_q && (rd_core_q == IW'(gi));
    end

    // First requester found scanning upward from rr_ptr, wrapping at NUM_CORES.
    always_comb begin
        int  idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        winner = rr_ptr_q;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_CORES;
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

    assign owner_inc  = (owner_q == IW'(NUM_CORES - 1)) ? '0 : owner_q + IW'(1);
    assign beat_grant = (state_q == GRANT) && req_i[owner_q];

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    owner_d    = winner;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (req_i[owner_q] && lock_i[owner_q] && (beat_cnt_q < BW'(BURST_MAX - 1))) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                end else begin
                    state_d  = IDLE;
                    rr_ptr_d = owner_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            rd_core_q  <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            rd_pend_q  <= beat_grant && !we_i[owner_q];
            if (beat_grant && !we_i[owner_q]) begin
                rd_core_q <= owner_q;
            end
            if (rd_pend_q) begin
                rdata_q <= mem_rdata_i;
            end
        end
    end

    // Memory-side fields are forced to zero whenever no beat is being issued.
    assign mem_req_o   = beat_grant;
    assign mem_we_o    = beat_grant && we_i[owner_q];
    assign mem_addr_o  = beat_grant ? addr_arr[owner_q] : '0;
    assign mem_wdata_o = beat_grant ? wdata_arr[owner_q] : '0;
    assign rdata_o     = rd_pend_q ? mem_rdata_i : rdata_q;
    assign owner_id_o  = owner_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mp_mem_arbiter.sv
// Directed bench for mp_mem_arbiter: 4-core instance with a memory model,
// plus a 3-core instance for non-power-of-2 round-robin wrap.
module tb_mp_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, lock, we;
    logic [43:0] addr;
    logic [31:0] wdata;
    logic [3:0]  gnt, rvalid;
    logic [7:0]  rdata;
    logic        mem_req, mem_we;
    logic [10:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [1:0]  owner_id;
    logic        busy;

    logic [2:0]  req3;
    logic [2:0]  gnt3, rvalid3;
    logic [7:0]  rdata3;
    logic        mem_req3, mem_we3;
    logic [10:0] mem_addr3;
    logic [7:0]  mem_wdata3;
    logic [1:0]  owner3;
    logic        busy3;

    logic        pl_we;
    logic [10:0] pl_addr;
    logic [7:0]  pl_data;
    logic [7:0]  mem [2048];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mp_mem_arbiter #(.NUM_CORES(4), .AW(11), .DW(8), .BURST_MAX(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .lock_i(lock), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
        .rdata_o(rdata), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .owner_id_o(owner_id), .busy_o(busy)
    );

    mp_mem_arbiter #(.NUM_CORES(3), .AW(11), .DW(8), .BURST_MAX(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_i(req3), .lock_i(3'b000), .we_i(3'b000),
        .addr_i(33'd0), .wdata_i(24'd0), .gnt_o(gnt3), .rvalid_o(rvalid3),
        .rdata_o(rdata3), .mem_req_o(mem_req3), .mem_we_o(mem_we3),
        .mem_addr_o(mem_addr3), .mem_wdata_o(mem_wdata3), .mem_rdata_i(8'h00),
        .owner_id_o(owner3), .busy_o(busy3)
    );

    // Single-port memory: read data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        if (mem_req && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_req && !mem_we) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [10:0] a, input logic [7:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_we = 1'b0;
    endtask

    task automatic set_addr(input int c, input logic [10:0] a);
        addr[c*11 +: 11] = a;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; req = '0; lock = '0; we = '0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp2 [8]  = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};
        logic [3:0] exp3 [11] = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h4, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0};
        logic       busy3e [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0] expg3 [8] = '{3'h1, 3'h0, 3'h2, 3'h0, 3'h4, 3'h0, 3'h1, 3'h0};
        logic [1:0] expo3 [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0};

        rst_n = 1'b0; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        req3 = '0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        preload(11'h155, 8'hA5);
        preload(11'h010, 8'h11);
        preload(11'h011, 8'h22);
        preload(11'h012, 8'h33);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_owner", owner_id, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        // 1: core 2 single read
        set_addr(2, 11'h155); req = 4'b0100;
        step(); #1;
        chk("t1_gnt", gnt, 4'b0100);
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 11'h155);
        chk("t1_mem_we", mem_we, 0);
        chk("t1_owner", owner_id, 2);
        chk("t1_busy", busy, 1);
        chk("t1_rvalid_early", rvalid, 0);
        step(); req = 4'b0000; #1;
        chk("t1_rvalid", rvalid, 4'b0100);
        chk("t1_rdata", rdata, 8'hA5);
        chk("t1_gnt_off", gnt, 0);
        chk("t1_idle", busy, 0);
        step(); #1;
        chk("t1_rvalid_pulse", rvalid, 0);
        chk("t1_rdata_hold", rdata, 8'hA5);

        // 2: cores 0,1,3 contend with rr_ptr=0
        do_reset();
        req = 4'b1011;
        for (int i = 0; i < 8; i++) begin
            step(); #1;
            chk($sformatf("t2_gnt_c%0d", i + 1), gnt, exp2[i]);
        end
        req = 4'b0000;

        // 3: core 1 locked writes, 6 queued, core 2 also waiting
        do_reset();
        set_addr(1, 11'h100); set_addr(2, 11'h200);
        wdata = 32'h0000_5A00; we = 4'b0110; lock = 4'b0010; req = 4'b0110;
        for (int i = 0; i < 11; i++) begin
            step();
            if (i == 6) req[2] = 1'b0;
            if (i == 9) req[1] = 1'b0;
            #1;
            chk($sformatf("t3_gnt_c%0d", i + 1), gnt, exp3[i]);
            chk($sformatf("t3_busy_c%0d", i + 1), busy, busy3e[i]);
        end
        lock = '0; we = '0;

        // 4: core 0 locked 3-beat read, lock dropped on beat 3
        do_reset();
        set_addr(0, 11'h010); lock = 4'b0001; req = 4'b0001;
        step(); #1;
        chk("t4_b1_gnt", gnt, 4'b0001);
        chk("t4_b1_addr", mem_addr, 11'h010);
        chk("t4_b1_rvalid", rvalid, 0);
        step(); set_addr(0, 11'h011); #1;
        chk("t4_b2_gnt", gnt, 4'b0001);
        chk("t4_b2_addr", mem_addr, 11'h011);
        chk("t4_rv1", rvalid, 4'b0001);
        chk("t4_rd1", rdata, 8'h11);
        step(); set_addr(0, 11'h012); lock = 4'b0000; #1;
        chk("t4_b3_gnt", gnt, 4'b0001);
        chk("t4_rv2", rvalid, 4'b0001);
        chk("t4_rd2", rdata, 8'h22);
        step(); req = 4'b0000; #1;
        chk("t4_release_gnt", gnt, 0);
        chk("t4_release_busy", busy, 0);
        chk("t4_rv3", rvalid, 4'b0001);
        chk("t4_rd3", rdata, 8'h33);
        step(); #1;
        chk("t4_rv_end", rvalid, 0);
        chk("t4_rd_hold", rdata, 8'h33);

        // 5: asynchronous reset in the middle of a locked read burst
        set_addr(0, 11'h010); lock = 4'b0001; req = 4'b0001;
        step(); #1;
        chk("t5_b1_gnt", gnt, 4'b0001);
        step(); #1;
        chk("t5_b2_gnt", gnt, 4'b0001);
        rst_n = 1'b0;
        #1;
        chk("t5_async_gnt", gnt, 0);
        chk("t5_async_rvalid", rvalid, 0);
        chk("t5_async_rdata", rdata, 0);
        chk("t5_async_mem_req", mem_req, 0);
        chk("t5_async_mem_addr", mem_addr, 0);
        chk("t5_async_busy", busy, 0);
        lock = 4'b0000; we = 4'b1010; req = 4'b1010;
        #2;
        rst_n = 1'b1;
        step(); #1;
        chk("t5_post_gnt", gnt, 4'b0010);
        chk("t5_post_owner", owner_id, 1);
        chk("t5_post_rvalid1", rvalid, 0);
        step(); req = 4'b0000; we = 4'b0000; #1;
        chk("t5_post_rvalid2", rvalid, 0);
        step(); #1;

        // 6: core 3 writes top address, core 0 reads it back
        set_addr(3, 11'h7FF); wdata = 32'h3C00_0000; we = 4'b1000; req = 4'b1000;
        step(); #1;
        chk("t6_wr_gnt", gnt, 4'b1000);
        chk("t6_wr_we", mem_we, 1);
        chk("t6_wr_addr", mem_addr, 11'h7FF);
        chk("t6_wr_data", mem_wdata, 8'h3C);
        step(); req = 4'b0001; we = 4'b0000; set_addr(0, 11'h7FF); #1;
        chk("t6_wr_no_rvalid", rvalid, 0);
        chk("t6_idle_gnt", gnt, 0);
        step(); #1;
        chk("t6_rd_gnt", gnt, 4'b0001);
        chk("t6_rd_addr", mem_addr, 11'h7FF);
        chk("t6_rd_we", mem_we, 0);
        step(); req = 4'b0000; #1;
        chk("t6_rvalid", rvalid, 4'b0001);
        chk("t6_rdata", rdata, 8'h3C);

        // 7: three-core instance wraps owner 2 -> 0
        req3 = 3'b111;
        for (int i = 0; i < 8; i++) begin
            step(); #1;
            chk($sformatf("t7_gnt3_c%0d", i + 1), gnt3, expg3[i]);
            chk($sformatf("t7_owner3_c%0d", i + 1), owner3, expo3[i]);
        end
        req3 = 3'b000;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
